// File: rtl/data_mem_ctrl_if.sv
// Load/store bus between the pipeline (master) and the data memory controller (slave).
interface data_mem_ctrl_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memread;
  logic        memwrite;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;
  logic        err;

  modport master (
    output addr, write_data, memread, memwrite, sign_mask,
    input  read_data, clk_stall, err
  );

  modport slave (
    input  addr, write_data, memread, memwrite, sign_mask,
    output read_data, clk_stall, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: word-addressed data array plus MMIO output registers,
// byte/half/word loads and read-modify-write stores through an IDLE/WAIT/FETCH/COMMIT FSM.
module data_mem_ctrl #(
  parameter int unsigned DATA_DEPTH = 1024,
  parameter logic [31:0] DATA_BASE  = 32'h1000,
  parameter logic [31:0] MMIO_BASE  = 32'h2000,
  parameter int unsigned MMIO_CH    = 1,
  parameter int unsigned WAIT_CYC   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  data_mem_ctrl_if.slave          bus,
  output logic [32*MMIO_CH-1:0]   mmio_out,
  output logic [7:0]              led
);

  localparam int unsigned AW        = $clog2(DATA_DEPTH);
  localparam int unsigned CW        = (MMIO_CH > 1) ? $clog2(MMIO_CH) : 1;
  localparam logic [31:0] DATA_SPAN = 32'(4 * DATA_DEPTH);
  localparam logic [31:0] MMIO_SPAN = 32'(4 * MMIO_CH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH, S_COMMIT} state_e;

  state_e      r_state, w_next;
  logic [2:0]  r_wcnt;
  logic [31:0] r_addr, r_wdata, r_buf, r_read_data;
  logic [3:0]  r_mask;
  logic        r_wr, r_both, r_clk_stall, r_err;
  logic [31:0] r_mem  [DATA_DEPTH];
  logic [31:0] r_mmio [MMIO_CH];

  logic          w_req, w_latch, w_wait, w_fetch, w_commit, w_mem_we, w_mmio_we;
  logic [31:0]   w_data_off, w_mmio_off, w_merged, w_load;
  logic          w_in_data, w_in_mmio, w_sz_byte, w_sz_half, w_sz_word, w_fault, w_sx;
  logic [AW-1:0] w_data_idx;
  logic [CW-1:0] w_mmio_idx;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign w_req = bus.memread | bus.memwrite;

  // Address window and size decode on the latched request
  always_comb begin
    w_data_off = r_addr - DATA_BASE;
    w_mmio_off = r_addr - MMIO_BASE;
    w_in_data  = (r_addr >= DATA_BASE) && (w_data_off < DATA_SPAN);
    w_in_mmio  = (r_addr >= MMIO_BASE) && (w_mmio_off < MMIO_SPAN);
    w_data_idx = w_data_off[AW+1:2];
    w_mmio_idx = w_mmio_off[CW+1:2];
    w_sz_byte  = (r_mask[2:0] == 3'b001);
    w_sz_half  = (r_mask[2:0] == 3'b011);
    w_sz_word  = (r_mask[2:0] == 3'b111);
    w_sx       = r_mask[3];
    w_fault    = !(w_in_data || w_in_mmio)
               || (w_sz_half && r_addr[0])
               || (w_sz_word && (r_addr[1:0] != 2'b00))
               || !(w_sz_byte || w_sz_half || w_sz_word)
               || r_both;
  end

  // Lane merge for stores and lane extract/extend for loads
  always_comb begin
    w_merged = r_buf;
    if (w_sz_word)      w_merged = r_wdata;
    else if (w_sz_half) w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    else                w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    w_byte = r_buf[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_buf[{r_addr[1], 4'b0000} +: 16];
    if (w_sz_word)      w_load = r_buf;
    else if (w_sz_half) w_load = {{16{w_sx & w_half[15]}}, w_half};
    else                w_load = {{24{w_sx & w_byte[7]}}, w_byte};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_next = (WAIT_CYC > 0) ? S_WAIT : S_FETCH;
      S_WAIT:   if (r_wcnt == 3'(WAIT_CYC - 1)) w_next = S_FETCH;
      S_FETCH:  w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_latch   = 1'b0;
    w_wait    = 1'b0;
    w_fetch   = 1'b0;
    w_commit  = 1'b0;
    w_mem_we  = 1'b0;
    w_mmio_we = 1'b0;
    case (r_state)
      S_IDLE:   w_latch = w_req;
      S_WAIT:   w_wait  = 1'b1;
      S_FETCH:  w_fetch = 1'b1;
      S_COMMIT: begin
        w_commit  = 1'b1;
        w_mem_we  = r_wr && !w_fault && w_in_data;
        w_mmio_we = r_wr && !w_fault && w_in_mmio;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_wr        <= 1'b0;
      r_both      <= 1'b0;
      r_clk_stall <= 1'b0;
      r_err       <= 1'b0;
      r_read_data <= '0;
      for (int i = 0; i < int'(MMIO_CH); i++) r_mmio[i] <= '0;
    end else begin
      if (w_latch) begin
        r_addr  <= bus.addr;
        r_wdata <= bus.write_data;
        r_mask  <= bus.sign_mask;
        r_wr    <= bus.memwrite;
        r_both  <= bus.memread & bus.memwrite;
        r_wcnt  <= '0;
      end else if (w_wait) begin
        r_wcnt  <= r_wcnt + 3'd1;
      end
      r_clk_stall <= (w_next != S_IDLE);
      r_err       <= w_commit & w_fault;
      if (w_commit) begin
        if (w_fault)    r_read_data <= '0;
        else if (!r_wr) r_read_data <= w_load;
      end
      for (int i = 0; i < int'(MMIO_CH); i++) begin
        if (w_mmio_we && (w_mmio_idx == CW'(i))) r_mmio[i] <= w_merged;
      end
    end
  end

  // Array port: read into the word buffer in FETCH, merged write in COMMIT
  always_ff @(posedge clk) begin
    if (w_fetch) begin
      if (w_in_data)      r_buf <= r_mem[w_data_idx];
      else if (w_in_mmio) r_buf <= r_mmio[w_mmio_idx];
      else                r_buf <= '0;
    end
    if (w_mem_we) r_mem[w_data_idx] <= w_merged;
  end

  genvar g;
  generate
    for (g = 0; g < int'(MMIO_CH); g++) begin : g_mmio
      assign mmio_out[32*g +: 32] = r_mmio[g];
    end
  endgenerate

  assign led           = r_mmio[0][7:0];
  assign bus.read_data = r_read_data;
  assign bus.clk_stall = r_clk_stall;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with no wait states and two MMIO
// channels, one with three wait states.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if b0();
  data_mem_ctrl_if b1();
  logic [63:0] mo0;
  logic [31:0] mo1;
  logic [7:0]  led0, led1;

  data_mem_ctrl #(.WAIT_CYC(0), .MMIO_CH(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave), .mmio_out(mo0), .led(led0));
  data_mem_ctrl #(.WAIT_CYC(3), .MMIO_CH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .mmio_out(mo1), .led(led1));

  localparam logic [3:0] MB  = 4'b0001;
  localparam logic [3:0] MH  = 4'b0011;
  localparam logic [3:0] MW  = 4'b0111;
  localparam logic [3:0] MSB = 4'b1001;
  localparam logic [3:0] MSH = 4'b1011;

  int errors = 0;
  int checks = 0;
  int stall_n;
  logic [31:0] rdata_v;
  logic err_v, err_after;
  logic [5:0] seq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      b0.memread = rd; b0.memwrite = wr; b0.sign_mask = m; b0.addr = a; b0.write_data = d;
    end else begin
      b1.memread = rd; b1.memwrite = wr; b1.sign_mask = m; b1.addr = a; b1.write_data = d;
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the DUT idle.
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
    drive(sel, rd, wr, m, a, d);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
    stall_n = 0;
    while (((sel == 0) ? b0.clk_stall : b1.clk_stall) && stall_n < 50) begin
      stall_n++;
      @(negedge clk);
    end
    err_v   = (sel == 0) ? b0.err : b1.err;
    rdata_v = (sel == 0) ? b0.read_data : b1.read_data;
    @(negedge clk);
    err_after = (sel == 0) ? b0.err : b1.err;
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
    #2;
    chk("rst_rdata", 64'(b0.read_data), 64'h0);
    chk("rst_stall", 64'(b0.clk_stall), 64'h0);
    chk("rst_err",   64'(b0.err), 64'h0);
    chk("rst_mmio",  mo0, 64'h0);

    // First access launched together with reset release
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b0, 1'b1, MW, 32'h1004, 32'hDEADBEEF);
    chk("st_word_stall", 64'(stall_n), 64'd2);
    chk("st_word_err",   64'(err_v), 64'h0);
    access(0, 1'b1, 1'b0, MW, 32'h1004, 32'h0);
    chk("ld_word",       64'(rdata_v), 64'hDEADBEEF);
    chk("ld_word_stall", 64'(stall_n), 64'd2);

    // Byte store merge and extension
    access(0, 1'b0, 1'b1, MW, 32'h1004, 32'h11223344);
    access(0, 1'b0, 1'b1, MB, 32'h1005, 32'h00000080);
    access(0, 1'b1, 1'b0, MSB, 32'h1005, 32'h0);
    chk("ld_sbyte", 64'(rdata_v), 64'hFFFFFF80);
    access(0, 1'b1, 1'b0, MH, 32'h1004, 32'h0);
    chk("ld_uhalf", 64'(rdata_v), 64'h00008044);
    access(0, 1'b1, 1'b0, MW, 32'h1004, 32'h0);
    chk("ld_merged", 64'(rdata_v), 64'h11228044);

    // Upper half store, signed half load
    access(0, 1'b0, 1'b1, MH, 32'h1006, 32'h00008001);
    access(0, 1'b1, 1'b0, MSH, 32'h1006, 32'h0);
    chk("ld_shalf", 64'(rdata_v), 64'hFFFF8001);
    access(0, 1'b1, 1'b0, MB, 32'h1007, 32'h0);
    chk("ld_ubyte3", 64'(rdata_v), 64'h00000080);
    access(0, 1'b1, 1'b0, MW, 32'h1004, 32'h0);
    chk("ld_half_merged", 64'(rdata_v), 64'h80018044);

    // Last data word
    access(0, 1'b0, 1'b1, MW, 32'h1FFC, 32'h13579BDF);
    chk("st_top_err", 64'(err_v), 64'h0);
    access(0, 1'b1, 1'b0, MW, 32'h1FFC, 32'h0);
    chk("ld_top", 64'(rdata_v), 64'h13579BDF);

    // MMIO
    access(0, 1'b0, 1'b1, MW, 32'h2000, 32'h000000A5);
    chk("led", 64'(led0), 64'hA5);
    chk("mmio_ch0", mo0, 64'h00000000_000000A5);
    access(0, 1'b0, 1'b1, MW, 32'h2004, 32'h12345678);
    chk("mmio_ch1", mo0, 64'h12345678_000000A5);
    access(0, 1'b0, 1'b1, MB, 32'h2005, 32'h000000FF);
    chk("mmio_byte", mo0, 64'h1234FF78_000000A5);
    access(0, 1'b1, 1'b0, MW, 32'h2004, 32'h0);
    chk("mmio_ld", 64'(rdata_v), 64'h1234FF78);

    // Faults
    access(0, 1'b1, 1'b0, MW, 32'h1002, 32'h0);
    chk("f_unal_err",   64'(err_v), 64'h1);
    chk("f_unal_pulse", 64'(err_after), 64'h0);
    chk("f_unal_rdata", 64'(rdata_v), 64'h0);
    chk("f_unal_stall", 64'(stall_n), 64'd2);
    access(0, 1'b1, 1'b0, MW, 32'h1004, 32'h0);
    access(0, 1'b1, 1'b0, MW, 32'h0000, 32'h0);
    chk("f_range_err",   64'(err_v), 64'h1);
    chk("f_range_rdata", 64'(rdata_v), 64'h0);
    access(0, 1'b1, 1'b1, MW, 32'h1004, 32'h0);
    chk("f_both_err", 64'(err_v), 64'h1);
    access(0, 1'b0, 1'b1, MH, 32'h1005, 32'h0000FFFF);
    chk("f_half_odd_err", 64'(err_v), 64'h1);
    access(0, 1'b0, 1'b1, MB, 32'h2008, 32'h000000EE);
    chk("f_mmio_top_err", 64'(err_v), 64'h1);
    chk("f_mmio_kept", mo0, 64'h1234FF78_000000A5);
    access(0, 1'b1, 1'b0, 4'b0101, 32'h1004, 32'h0);
    chk("f_mask_err", 64'(err_v), 64'h1);
    access(0, 1'b1, 1'b0, MW, 32'h1004, 32'h0);
    chk("f_array_kept", 64'(rdata_v), 64'h80018044);
    chk("f_ok_err", 64'(err_v), 64'h0);

    // Request held across two accesses
    drive(0, 1'b1, 1'b0, MW, 32'h1004, 32'h0);
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seq = {seq[4:0], b0.clk_stall};
    end
    drive(0, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
    chk("held_seq",   64'(seq), 64'b110110);
    chk("held_rdata", 64'(b0.read_data), 64'h80018044);

    // Three wait states
    access(1, 1'b0, 1'b1, MW, 32'h1004, 32'h8001ABCD);
    chk("w3_st_stall", 64'(stall_n), 64'd5);
    access(1, 1'b1, 1'b0, MSH, 32'h1006, 32'h0);
    chk("w3_ld_shalf", 64'(rdata_v), 64'hFFFF8001);
    chk("w3_ld_stall", 64'(stall_n), 64'd5);

    // Reset during FETCH of a store
    access(0, 1'b0, 1'b1, MW, 32'h1008, 32'h0BADF00D);
    drive(0, 1'b0, 1'b1, MW, 32'h1008, 32'h12345678);
    @(negedge clk);
    chk("rf_in_fetch", 64'(b0.clk_stall), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rf_stall", 64'(b0.clk_stall), 64'h0);
    chk("rf_rdata", 64'(b0.read_data), 64'h0);
    chk("rf_mmio",  mo0, 64'h0);
    chk("rf_led",   64'(led0), 64'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b1, 1'b0, MW, 32'h1008, 32'h0);
    chk("rf_word_kept", 64'(rdata_v), 64'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
